// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 detector slice.
// Used by the serializer and by the detector's bench.
package seq_pkg;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } ser_state_t;

    localparam logic SER_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out feeder for the 1011 detector.
// Words stream back-to-back when a load lands on the last bit.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             x_nxt;
    logic             accept;
    logic             cnt_zero;

    assign cnt_zero   = (cnt == '0);
    assign x_valid    = (state == S_SHIFT);
    assign last       = x_valid && cnt_zero;
    assign load_ready = !x_valid || cnt_zero;
    assign accept     = load_valid && load_ready;

    // State, shift register, bit counter and serial output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            x     <= SER_IDLE_LEVEL;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            x     <= x_nxt;
        end
    end

    // Next state: load on accept, otherwise rotate out the remaining bits
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        x_nxt     = x;
        if (accept) begin
            state_nxt = S_SHIFT;
            shreg_nxt = data_in;
            cnt_nxt   = CNT_TOP;
            x_nxt     = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        end else begin
            unique case (state)
                S_IDLE: begin
                    x_nxt = SER_IDLE_LEVEL;
                end
                S_SHIFT: begin
                    if (!cnt_zero) begin
                        // Rotate so every bit stays live; only the
                        // bits ahead of the output end are ever used.
                        if (MSB_FIRST) begin
                            shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                            x_nxt     = shreg[WIDTH-2];
                        end else begin
                            shreg_nxt = {shreg[0], shreg[WIDTH-1:1]};
                            x_nxt     = shreg[1];
                        end
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        x_nxt     = SER_IDLE_LEVEL;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    x_nxt     = SER_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
